// File: rtl/avl_sdram_pkg.sv
// Shared types and default widths for the Avalon-MM SDRAM responder slice.
package avl_sdram_pkg;

   localparam int DEF_ADDR_W = 25;
   localparam int DEF_DATA_W = 16;

   // Command-phase states: wait for a request, burn the stall, then offer the slot
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_READY = 2'd2
   } avlState_e;

endpackage

// File: rtl/avl_sdram_responder_if.sv
// Avalon-MM bus bundle between an initiator and the SDRAM responder.
interface avl_sdram_responder_if
   import avl_sdram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable_n;
   logic                chipselect;
   logic                read_n;
   logic                write_n;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, byteenable_n, chipselect, read_n, write_n, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable_n, chipselect, read_n, write_n, writedata,
      output readdata, readdatavalid, waitrequest
   );

endinterface

// File: rtl/avl_rd_pipe.sv
// Fixed-latency read return pipe: carries a valid flag and the sampled word,
// with the last data stage only reloading on a valid so readdata holds.
module avl_rd_pipe
   import avl_sdram_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [LATENCY-1:0] vld_q;
   logic [DATA_W-1:0]  dat_q [LATENCY];

   // Shift valid/data one stage per clock; flush drops every in-flight read
   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= valid_i;
         if (valid_i) begin
            dat_q[0] <= data_i;
         end
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign valid_o = vld_q[LATENCY-1];
   assign data_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/avl_sdram_responder.sv
// Avalon-MM slave standing in for the SDRAM path: stalled command acceptance,
// byte-masked word memory, pipelined reads and a sticky protocol error flag.
module avl_sdram_responder
   import avl_sdram_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int MEM_WORDS    = 1024,
   parameter int WAIT_CYCLES  = 2,
   parameter int READ_LATENCY = 3,
   parameter int MAX_PENDING  = 2
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   avl_sdram_responder_if.slave  avl,
   output logic                  protocol_err
);

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0]  STALL_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);

   avlState_e         state_q;
   logic [CNT_W-1:0]  stallCnt_q;
   logic [PEND_W-1:0] pendCnt_q;
   logic [PEND_W-1:0] pendCnt_d;
   logic              protoErr_q;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   logic              request;
   logic              isWrite;
   logic              isRead;
   logic              accept;
   logic              rdAccept;
   logic              wrAccept;
   logic [IDX_W-1:0]  idx;
   logic              unusedAddrBits;

   // Write wins when both strobes are low, so a read is only a pure read
   assign isWrite  = ~avl.write_n;
   assign isRead   = ~avl.read_n & avl.write_n;
   assign request  = avl.chipselect & (isWrite | ~avl.read_n);
   assign avl.waitrequest = (state_q != S_READY) | (isRead & (pendCnt_q == PEND_MAX));
   assign accept   = request & ~avl.waitrequest;
   assign rdAccept = accept & isRead;
   assign wrAccept = accept & isWrite;

   // Only the low address bits index memory; upper bits alias
   assign idx            = avl.address[IDX_W-1:0];
   assign unusedAddrBits = ^avl.address[ADDR_W-1:IDX_W];

   // Command FSM: stall WAIT_CYCLES after each fresh request, then offer one accept
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= S_IDLE;
         stallCnt_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (request) begin
                  stallCnt_q <= STALL_LOAD;
                  state_q    <= (STALL_LOAD == '0) ? S_READY : S_STALL;
               end
            end
            S_STALL: begin
               if (!request) begin
                  state_q <= S_IDLE;
               end else begin
                  stallCnt_q <= stallCnt_q - CNT_W'(1);
                  if (stallCnt_q == CNT_W'(1)) begin
                     state_q <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (accept || !request) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outstanding reads: up on accept, down on return, flat when both coincide
   always_comb begin
      pendCnt_d = pendCnt_q;
      if (rdAccept && !avl.readdatavalid) begin
         pendCnt_d = pendCnt_q + PEND_W'(1);
      end else if (!rdAccept && avl.readdatavalid) begin
         pendCnt_d = pendCnt_q - PEND_W'(1);
      end
   end

   // Pending counter and sticky error flag
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         pendCnt_q  <= '0;
         protoErr_q <= 1'b0;
      end else begin
         pendCnt_q <= pendCnt_d;
         if (avl.chipselect && !avl.read_n && !avl.write_n) begin
            protoErr_q <= 1'b1;
         end
      end
   end

   // Byte-masked memory write; blocked during reset so a write is all-or-nothing
   always_ff @(posedge clk_clk) begin
      if (!reset_reset && wrAccept) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (!avl.byteenable_n[b]) begin
               mem[idx][b*8 +: 8] <= avl.writedata[b*8 +: 8];
            end
         end
      end
   end

   assign protocol_err = protoErr_q;

   avl_rd_pipe #(
      .LATENCY (READ_LATENCY),
      .DATA_W  (DATA_W)
   ) u_rdPipe (
      .clk_i   (clk_clk),
      .flush_i (reset_reset),
      .valid_i (rdAccept),
      .data_i  (mem[idx]),
      .valid_o (avl.readdatavalid),
      .data_o  (avl.readdata)
   );

endmodule

// File: tb/tb_avl_sdram_responder.sv
// Directed bench for avl_sdram_responder: default instance plus a
// WAIT_CYCLES=1 / MAX_PENDING=1 instance for the pending-limit case.
module tb_avl_sdram_responder;

   logic clk;
   logic reset_reset;
   logic protoErrA;
   logic protoErrB;

   int vectors;
   int miscompares;

   avl_sdram_responder_if #(.ADDR_W(25), .DATA_W(16)) aIf ();
   avl_sdram_responder_if #(.ADDR_W(25), .DATA_W(16)) bIf ();

   avl_sdram_responder dutA (
      .clk_clk      (clk),
      .reset_reset  (reset_reset),
      .avl          (aIf),
      .protocol_err (protoErrA)
   );

   avl_sdram_responder #(
      .WAIT_CYCLES (1),
      .MAX_PENDING (1)
   ) dutB (
      .clk_clk      (clk),
      .reset_reset  (reset_reset),
      .avl          (bIf),
      .protocol_err (protoErrB)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idleA();
      aIf.chipselect   = 1'b0;
      aIf.read_n       = 1'b1;
      aIf.write_n      = 1'b1;
      aIf.byteenable_n = 2'b00;
      aIf.address      = '0;
      aIf.writedata    = '0;
   endtask

   task automatic idleB();
      bIf.chipselect   = 1'b0;
      bIf.read_n       = 1'b1;
      bIf.write_n      = 1'b1;
      bIf.byteenable_n = 2'b00;
      bIf.address      = '0;
      bIf.writedata    = '0;
   endtask

   // Present one command on A, count cycles of waitrequest, release after accept edge
   task automatic applyStimulus(input bit isRd, input bit isWr, input logic [24:0] addr,
                                input logic [15:0] data, input logic [1:0] ben,
                                output int waitCnt);
      @(negedge clk);
      aIf.chipselect   = 1'b1;
      aIf.read_n       = ~isRd;
      aIf.write_n      = ~isWr;
      aIf.address      = addr;
      aIf.writedata    = data;
      aIf.byteenable_n = ben;
      waitCnt = 0;
      #1;
      while (aIf.waitrequest && waitCnt < 50) begin
         @(negedge clk);
         #1;
         waitCnt++;
      end
      @(posedge clk);
      #1;
      idleA();
   endtask

   // Count cycles from the accept edge to readdatavalid on A
   task automatic waitValid(output int lat, output logic [15:0] data);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!aIf.readdatavalid && lat < 20);
      data = aIf.readdata;
   endtask

   int          wc;
   int          lat;
   int          guard;
   int          pulses;
   int          v1Cycle;
   int          v2Cycle;
   int          low2;
   bit          accepted2;
   bit          sawValid;
   logic        wrAtV1;
   logic [15:0] rd;
   logic [15:0] d1;
   logic [15:0] d2;

   initial begin
      vectors     = 0;
      miscompares = 0;
      idleA();
      idleB();

      // Reset state
      reset_reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstWaitreq", aIf.waitrequest, 1);
      checkOutput("rstRdValid", aIf.readdatavalid, 0);
      checkOutput("rstRdData", aIf.readdata, 16'h0000);
      checkOutput("rstProtoErr", protoErrA, 0);
      checkOutput("rstPending", dutA.pendCnt_q, 0);
      reset_reset = 1'b0;

      // Full write then read of 0x100
      applyStimulus(0, 1, 25'h000100, 16'hABCD, 2'b00, wc);
      checkOutput("wr1Wait", wc, 2);
      applyStimulus(1, 0, 25'h000100, 16'h0000, 2'b00, wc);
      checkOutput("rd1Wait", wc, 2);
      waitValid(lat, rd);
      checkOutput("rd1Latency", lat, 3);
      checkOutput("rd1Data", rd, 16'hABCD);
      @(negedge clk);
      checkOutput("rd1PulseWidth", aIf.readdatavalid, 0);
      checkOutput("rd1DataHold", aIf.readdata, 16'hABCD);

      // Low byte only
      applyStimulus(0, 1, 25'h000100, 16'h1234, 2'b10, wc);
      applyStimulus(1, 0, 25'h000100, 16'h0000, 2'b11, wc);
      waitValid(lat, rd);
      checkOutput("byteMaskData", rd, 16'hAB34);

      // All enables off: accepted, memory unchanged
      applyStimulus(0, 1, 25'h000100, 16'hFFFF, 2'b11, wc);
      checkOutput("noByteWait", wc, 2);
      applyStimulus(1, 0, 25'h000100, 16'h0000, 2'b00, wc);
      waitValid(lat, rd);
      checkOutput("noByteData", rd, 16'hAB34);

      // Aliasing: 0x500 maps onto 0x100 with 1024 words
      applyStimulus(0, 1, 25'h000500, 16'h5A5A, 2'b00, wc);
      applyStimulus(1, 0, 25'h000100, 16'h0000, 2'b00, wc);
      waitValid(lat, rd);
      checkOutput("aliasData", rd, 16'h5A5A);

      // Both strobes low: write wins, error sticks, no read returned
      applyStimulus(1, 1, 25'h000010, 16'h00FF, 2'b00, wc);
      checkOutput("protoWait", wc, 2);
      checkOutput("protoErrSet", protoErrA, 1);
      sawValid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (aIf.readdatavalid) sawValid = 1'b1;
      end
      checkOutput("protoNoRead", sawValid, 0);
      applyStimulus(1, 0, 25'h000010, 16'h0000, 2'b00, wc);
      waitValid(lat, rd);
      checkOutput("protoRdData", rd, 16'h00FF);
      checkOutput("protoErrHeld", protoErrA, 1);

      // Instance B: preload two words
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bIf.chipselect   = 1'b1;
         bIf.write_n      = 1'b0;
         bIf.byteenable_n = 2'b00;
         bIf.address      = 25'(k + 1);
         bIf.writedata    = (k == 0) ? 16'h1111 : 16'h2222;
         guard = 0;
         #1;
         while (bIf.waitrequest && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
         end
         checkOutput("bWrWait", guard, 1);
         @(posedge clk);
         #1;
         idleB();
      end

      // Instance B: back-to-back reads against the single pending slot
      @(negedge clk);
      bIf.chipselect = 1'b1;
      bIf.read_n     = 1'b0;
      bIf.address    = 25'd1;
      guard = 0;
      #1;
      while (bIf.waitrequest && guard < 20) begin
         @(negedge clk);
         #1;
         guard++;
      end
      checkOutput("bRd1Wait", guard, 1);
      @(posedge clk);
      #1;
      bIf.address = 25'd2;
      pulses    = 0;
      v1Cycle   = -1;
      v2Cycle   = -1;
      low2      = -1;
      accepted2 = 1'b0;
      wrAtV1    = 1'b0;
      d1        = '0;
      d2        = '0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         #1;
         if (bIf.readdatavalid) begin
            pulses++;
            if (pulses == 1) begin
               v1Cycle = cyc;
               wrAtV1  = bIf.waitrequest;
               d1      = bIf.readdata;
            end else begin
               v2Cycle = cyc;
               d2      = bIf.readdata;
            end
         end
         if (!accepted2 && bIf.chipselect && !bIf.waitrequest) begin
            low2      = cyc;
            accepted2 = 1'b1;
            @(posedge clk);
            #1;
            idleB();
         end
      end
      checkOutput("bPulseCount", pulses, 2);
      checkOutput("bValid1Cycle", v1Cycle, 3);
      checkOutput("bWaitAtValid1", wrAtV1, 1);
      checkOutput("bRd2AcceptCycle", low2, 4);
      checkOutput("bValid2Cycle", v2Cycle, 7);
      checkOutput("bRd1Data", d1, 16'h1111);
      checkOutput("bRd2Data", d2, 16'h2222);

      // Reset one cycle after a read accept discards the read
      applyStimulus(1, 0, 25'h000010, 16'h0000, 2'b00, wc);
      @(negedge clk);
      reset_reset = 1'b1;
      @(posedge clk);
      #1;
      reset_reset = 1'b0;
      sawValid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (aIf.readdatavalid) sawValid = 1'b1;
      end
      checkOutput("midRstNoValid", sawValid, 0);
      checkOutput("midRstWaitreq", aIf.waitrequest, 1);
      checkOutput("midRstPending", dutA.pendCnt_q, 0);
      checkOutput("midRstRdData", aIf.readdata, 16'h0000);
      checkOutput("midRstProtoErr", protoErrA, 0);
      applyStimulus(1, 0, 25'h000100, 16'h0000, 2'b00, wc);
      waitValid(lat, rd);
      checkOutput("postRstLatency", lat, 3);
      checkOutput("postRstData", rd, 16'h5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
